shutdown_gate: RTL and testbench
================================

# shutdown_gate

Parametrised safety gate between the controller's GPIO-driving peripherals (motor PWM, status LEDs) and the board pins. It forces a per-pin safe value and output-enable whenever any of NUM_IN shutdown requests (keys, kill switch, power-management faults) is active. It adds features the fixed-width disable stage lacks: input synchronisation, a release hold-off, per-input latching with an explicit re-arm, and trip diagnostics.

## Interface
- NUM_IN, 3: number of shutdown request inputs (≥1).
- NUM_IOS, 51: number of gated GPIO bits (≥1).
- RELEASE_CYCLES, 50000: consecutive clean cycles required before passthrough resumes (≥1).
- SAFE_VALUE, all 0: per-bit value driven on gpio_out while not ARMED.
- SAFE_OE, all 1: per-bit output-enable while not ARMED; 0 means the pin tristates.
- LATCH_MASK, all 0: per-input bit; 1 means a trip by that input persists until rearm.

Ports:
- clk  in  1  system clock; one clock only.
- reset  in  1  synchronous, active-high.
- shutdown  in  NUM_IN  active-high requests, asynchronous to clk; the top level inverts active-low keys.
- rearm  in  1  single-cycle pulse that clears latched trips.
- gpio_in  in  NUM_IOS  values from peripherals.
- gpio_out  out  NUM_IOS  registered gated values.
- gpio_oe  out  NUM_IOS  registered output-enables; all 1 when ARMED.
- tripped  out  1  registered; 1 in any state other than ARMED.
- trip_cause  out  NUM_IN  sticky OR of synchronised shutdown bits seen while not ARMED.
- trip_count  out  8  count of ARMED→TRIPPED transitions, saturating at 255.

## Operation
- Each shutdown bit passes through a 2-flop synchroniser (sync). Synchroniser flops reset to 0.
- States:
  - ARMED: outputs pass through.
  - TRIPPED: outputs safe.
  - HOLDOFF: outputs safe; release counter running.
- Transitions:
  - ARMED → TRIPPED when any sync bit is 1. trip_count increments.
  - TRIPPED → HOLDOFF when sync is all 0 and no latched cause is pending. A latched cause is pending when (trip_cause & LATCH_MASK) ≠ 0 and rearm is not asserted this cycle.
  - HOLDOFF → TRIPPED when any sync bit is 1. The counter clears.
  - HOLDOFF → ARMED when the counter reaches RELEASE_CYCLES-1 with sync all 0.
- rearm:
  - In TRIPPED, rearm clears trip_cause bits under LATCH_MASK, effective the next cycle.
  - In any other state, rearm is ignored.
  - rearm together with any sync bit at 1: the shutdown wins. State stays TRIPPED; trip_cause still ORs in the new bits.
- trip_cause accumulates in TRIPPED and HOLDOFF. Non-latched bits clear on entry to ARMED. Latched bits clear only by rearm or reset.
- Counter width is $clog2(RELEASE_CYCLES+1). The counter clears on every state entry and never wraps.
- Reset values:
  - state HOLDOFF, counter 0.
  - gpio_out = SAFE_VALUE, gpio_oe = SAFE_OE.
  - tripped = 1, trip_cause = 0, trip_count = 0.
- Reset asserted mid-trip or mid-holdoff aborts to these values; the full hold-off restarts.

## Timing
- Passthrough: gpio_out/gpio_oe at edge t+1 reflect gpio_in at edge t (latency 1).
- Trip: a shutdown bit sampled 1 at edge k is captured by sync flop 1 at edge k and flop 2 at edge k+1. gpio_out is safe and tripped = 1 from edge k+2.
- Glitch: a shutdown pulse shorter than one cycle may be missed. A pulse sampled high at any edge must trip.
- Release: from the first edge with sync all 0 in TRIPPED (non-latched case), ARMED and passthrough are visible after exactly RELEASE_CYCLES+1 further edges.
- After reset deassertion with quiet inputs, passthrough starts RELEASE_CYCLES edges later.

## Structure
- Package shutdown_gate_pkg holds:
  - the state enum (ARMED, TRIPPED, HOLDOFF);
  - the trip_count width constant (8) and the saturate value.
- Sub-module shutdown_sync holds the NUM_IN-wide 2-flop synchroniser with synchronous active-high reset. It is reused by other async-input peripherals.
- The top module holds the FSM, release counter, diagnostics and output registers. Expected size is about 150–250 lines.

## Test plan
Bench parameters: NUM_IN=3, NUM_IOS=8, RELEASE_CYCLES=16, SAFE_VALUE=8'h00, SAFE_OE=8'h0F, LATCH_MASK=3'b100.
- Reset: hold reset, gpio_in=8'hA5. Required: gpio_out=8'h00, gpio_oe=8'h0F, tripped=1. Then 16 edges after release: gpio_out=8'hA5, gpio_oe=8'hFF, tripped=0.
- Trip latency: in ARMED, set shutdown=3'b001 before edge k. Required: gpio_out=8'h00 from edge k+2, trip_count=1, trip_cause=3'b001.
- Non-latched release: drop shutdown[0]. Required: ARMED exactly 17 edges after sync clears, and trip_cause=0.
- Hold-off restart: re-assert shutdown[1] at holdoff count 10. Required: TRIPPED, and a full 16-cycle hold-off applies after it clears.
- Latched input: pulse shutdown[2] and clear it. Required: stays TRIPPED indefinitely. Then rearm pulse: HOLDOFF, then ARMED after 16 cycles. Also: rearm with shutdown[0]=1 in the same cycle keeps the state TRIPPED.
- Saturation: force 300 trips. Required: trip_count holds at 255.

Source files
------------

// File: rtl/shutdown_gate_pkg.sv
// Shared types and constants for the shutdown gate.
package shutdown_gate_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    TRIPPED = 2'd1,
    HOLDOFF = 2'd2
  } gate_state_e;

  localparam int TRIP_COUNT_W = 8;
  localparam logic [TRIP_COUNT_W-1:0] TRIP_COUNT_MAX = '1;

endpackage

// File: rtl/shutdown_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous request bits.
module shutdown_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] stable_d, stable_q;

  always_comb begin
    meta_d   = async_in;
    stable_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= '0;
      stable_q <= '0;
    end else begin
      meta_q   <= meta_d;
      stable_q <= stable_d;
    end
  end

  assign sync_out = stable_q;

endmodule

// File: rtl/shutdown_gate.sv
// Safety gate forcing GPIO pins to a safe value/enable while any shutdown
// request is active, with release hold-off, latched causes and diagnostics.
module shutdown_gate
  import shutdown_gate_pkg::*;
#(
  parameter int                  NUM_IN         = 3,
  parameter int                  NUM_IOS        = 51,
  parameter int                  RELEASE_CYCLES = 50000,
  parameter logic [NUM_IOS-1:0]  SAFE_VALUE     = '0,
  parameter logic [NUM_IOS-1:0]  SAFE_OE        = '1,
  parameter logic [NUM_IN-1:0]   LATCH_MASK     = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN-1:0]       shutdown,
  input  logic                    rearm,
  input  logic [NUM_IOS-1:0]      gpio_in,
  output logic [NUM_IOS-1:0]      gpio_out,
  output logic [NUM_IOS-1:0]      gpio_oe,
  output logic                    tripped,
  output logic [NUM_IN-1:0]       trip_cause,
  output logic [TRIP_COUNT_W-1:0] trip_count
);

  localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELEASE_CYCLES - 1);

  logic [NUM_IN-1:0] sync;

  shutdown_sync #(.WIDTH(NUM_IN)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (shutdown),
    .sync_out (sync)
  );

  gate_state_e             state_d, state_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic [NUM_IN-1:0]       cause_d, cause_q;
  logic [NUM_IN-1:0]       cause_base;
  logic [TRIP_COUNT_W-1:0] count_d, count_q;
  logic [NUM_IOS-1:0]      gpio_out_d, gpio_out_q;
  logic [NUM_IOS-1:0]      gpio_oe_d, gpio_oe_q;
  logic                    tripped_d, tripped_q;
  logic                    sync_any;
  logic                    latch_pending;

  always_comb begin
    state_d       = state_q;
    sync_any      = |sync;
    latch_pending = (|(cause_q & LATCH_MASK)) && !rearm;

    case (state_q)
      ARMED:   if (sync_any) state_d = TRIPPED;
      TRIPPED: if (!sync_any && !latch_pending) state_d = HOLDOFF;
      HOLDOFF: begin
        if (sync_any)              state_d = TRIPPED;
        else if (cnt_q == CNT_LAST) state_d = ARMED;
      end
      default: state_d = TRIPPED;
    endcase

    // Counter restarts on any state change, so each hold-off is a full one.
    if (state_d != state_q)      cnt_d = '0;
    else if (state_q == HOLDOFF) cnt_d = cnt_q + CNT_W'(1);
    else                         cnt_d = '0;

    cause_base = cause_q;
    if (state_q == TRIPPED && rearm) cause_base = cause_q & ~LATCH_MASK;
    if (state_d == ARMED) cause_d = cause_base & LATCH_MASK;
    else                  cause_d = cause_base | sync;

    count_d = count_q;
    if (state_q == ARMED && state_d == TRIPPED && count_q != TRIP_COUNT_MAX)
      count_d = count_q + TRIP_COUNT_W'(1);

    // Outputs follow the next state so the safe value lands with the trip.
    gpio_out_d = (state_d == ARMED) ? gpio_in : SAFE_VALUE;
    gpio_oe_d  = (state_d == ARMED) ? '1      : SAFE_OE;
    tripped_d  = (state_d != ARMED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HOLDOFF;
      cnt_q      <= '0;
      cause_q    <= '0;
      count_q    <= '0;
      gpio_out_q <= SAFE_VALUE;
      gpio_oe_q  <= SAFE_OE;
      tripped_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      count_q    <= count_d;
      gpio_out_q <= gpio_out_d;
      gpio_oe_q  <= gpio_oe_d;
      tripped_q  <= tripped_d;
    end
  end

  assign gpio_out   = gpio_out_q;
  assign gpio_oe    = gpio_oe_q;
  assign tripped    = tripped_q;
  assign trip_cause = cause_q;
  assign trip_count = count_q;

endmodule

// File: tb/tb_shutdown_gate.sv
// Directed self-checking bench for shutdown_gate with a short release hold-off.
module tb_shutdown_gate;

  logic       clk;
  logic       reset;
  logic [2:0] shutdown;
  logic       rearm;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic       tripped;
  logic [2:0] trip_cause;
  logic [7:0] trip_count;

  int checks   = 0;
  int failures = 0;
  int trips    = 0;

  shutdown_gate #(
    .NUM_IN         (3),
    .NUM_IOS        (8),
    .RELEASE_CYCLES (16),
    .SAFE_VALUE     (8'h00),
    .SAFE_OE        (8'h0F),
    .LATCH_MASK     (3'b100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .shutdown   (shutdown),
    .rearm      (rearm),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_oe    (gpio_oe),
    .tripped    (tripped),
    .trip_cause (trip_cause),
    .trip_count (trip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [2:0] sd, input logic rm, input logic [7:0] gi);
    shutdown = sd;
    rearm    = rm;
    gpio_in  = gi;
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete non-latched trip on shutdown[0] followed by the full release.
  task automatic tripAndRelease();
    applyStimulus(3'b001, 1'b0, 8'h5A);
    stepEdges(3);
    trips++;
    applyStimulus(3'b000, 1'b0, 8'h5A);
    stepEdges(19);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    reset = 1'b1;
    applyStimulus(3'b000, 1'b0, 8'hA5);
    stepEdges(3);
    checkOutput("reset_out", 32'(gpio_out), 32'h00);
    checkOutput("reset_oe", 32'(gpio_oe), 32'h0F);
    checkOutput("reset_tripped", 32'(tripped), 32'h1);
    checkOutput("reset_count", 32'(trip_count), 32'h0);

    reset = 1'b0;
    stepEdges(15);
    checkOutput("release_edge15_tripped", 32'(tripped), 32'h1);
    stepEdges(1);
    checkOutput("release_out", 32'(gpio_out), 32'hA5);
    checkOutput("release_oe", 32'(gpio_oe), 32'hFF);
    checkOutput("release_tripped", 32'(tripped), 32'h0);

    applyStimulus(3'b000, 1'b0, 8'h3C);
    stepEdges(1);
    checkOutput("pass_latency", 32'(gpio_out), 32'h3C);

    applyStimulus(3'b001, 1'b0, 8'hA5);
    stepEdges(2);
    checkOutput("trip_k1_out", 32'(gpio_out), 32'hA5);
    checkOutput("trip_k1_tripped", 32'(tripped), 32'h0);
    stepEdges(1);
    checkOutput("trip_k2_out", 32'(gpio_out), 32'h00);
    checkOutput("trip_k2_oe", 32'(gpio_oe), 32'h0F);
    checkOutput("trip_k2_tripped", 32'(tripped), 32'h1);
    checkOutput("trip_count1", 32'(trip_count), 32'h1);
    checkOutput("trip_cause1", 32'(trip_cause), 32'h1);

    applyStimulus(3'b000, 1'b0, 8'hA5);
    stepEdges(18);
    checkOutput("nonlatch_edge18_tripped", 32'(tripped), 32'h1);
    stepEdges(1);
    checkOutput("nonlatch_tripped", 32'(tripped), 32'h0);
    checkOutput("nonlatch_out", 32'(gpio_out), 32'hA5);
    checkOutput("nonlatch_cause", 32'(trip_cause), 32'h0);

    applyStimulus(3'b010, 1'b0, 8'hA5);
    stepEdges(3);
    checkOutput("restart_trip_count", 32'(trip_count), 32'h2);
    applyStimulus(3'b000, 1'b0, 8'hA5);
    stepEdges(13);
    applyStimulus(3'b010, 1'b0, 8'hA5);
    stepEdges(6);
    checkOutput("restart_held_tripped", 32'(tripped), 32'h1);
    checkOutput("restart_no_count", 32'(trip_count), 32'h2);
    applyStimulus(3'b000, 1'b0, 8'hA5);
    stepEdges(18);
    checkOutput("restart_edge18_tripped", 32'(tripped), 32'h1);
    stepEdges(1);
    checkOutput("restart_released", 32'(tripped), 32'h0);

    applyStimulus(3'b100, 1'b0, 8'hA5);
    stepEdges(1);
    applyStimulus(3'b000, 1'b0, 8'hA5);
    stepEdges(2);
    checkOutput("latch_tripped", 32'(tripped), 32'h1);
    checkOutput("latch_cause", 32'(trip_cause), 32'h4);
    stepEdges(40);
    checkOutput("latch_stuck", 32'(tripped), 32'h1);
    applyStimulus(3'b000, 1'b1, 8'hA5);
    stepEdges(1);
    checkOutput("rearm_cause_clear", 32'(trip_cause), 32'h0);
    applyStimulus(3'b000, 1'b0, 8'hA5);
    stepEdges(15);
    checkOutput("rearm_edge16_tripped", 32'(tripped), 32'h1);
    stepEdges(1);
    checkOutput("rearm_released", 32'(tripped), 32'h0);
    checkOutput("rearm_count", 32'(trip_count), 32'h3);

    applyStimulus(3'b100, 1'b0, 8'hA5);
    stepEdges(1);
    applyStimulus(3'b000, 1'b0, 8'hA5);
    stepEdges(5);
    applyStimulus(3'b001, 1'b0, 8'hA5);
    stepEdges(2);
    applyStimulus(3'b001, 1'b1, 8'hA5);
    stepEdges(1);
    applyStimulus(3'b001, 1'b0, 8'hA5);
    checkOutput("rearm_vs_sd_tripped", 32'(tripped), 32'h1);
    checkOutput("rearm_vs_sd_cause0", 32'(trip_cause[0]), 32'h1);
    stepEdges(20);
    checkOutput("rearm_vs_sd_held", 32'(tripped), 32'h1);
    applyStimulus(3'b000, 1'b0, 8'hA5);
    stepEdges(3);
    applyStimulus(3'b000, 1'b1, 8'hA5);
    stepEdges(1);
    applyStimulus(3'b000, 1'b0, 8'hA5);
    waited = 0;
    while (tripped !== 1'b0 && waited < 40) begin
      stepEdges(1);
      waited++;
    end
    checkOutput("rearm_vs_sd_release", 32'(tripped), 32'h0);
    checkOutput("rearm_vs_sd_count", 32'(trip_count), 32'h4);

    trips = 4;
    while (trips < 300) begin
      tripAndRelease();
      if (trips == 254) checkOutput("sat_254", 32'(trip_count), 32'd254);
      if (trips == 256) checkOutput("sat_256", 32'(trip_count), 32'd255);
    end
    checkOutput("sat_300", 32'(trip_count), 32'd255);
    checkOutput("sat_armed", 32'(tripped), 32'h0);

    applyStimulus(3'b001, 1'b0, 8'hC3);
    stepEdges(3);
    checkOutput("midtrip_tripped", 32'(tripped), 32'h1);
    reset = 1'b1;
    applyStimulus(3'b000, 1'b0, 8'hC3);
    stepEdges(2);
    checkOutput("midtrip_reset_out", 32'(gpio_out), 32'h00);
    checkOutput("midtrip_reset_oe", 32'(gpio_oe), 32'h0F);
    checkOutput("midtrip_reset_cause", 32'(trip_cause), 32'h0);
    checkOutput("midtrip_reset_count", 32'(trip_count), 32'h0);
    reset = 1'b0;
    stepEdges(15);
    checkOutput("midtrip_edge15_tripped", 32'(tripped), 32'h1);
    stepEdges(1);
    checkOutput("midtrip_released_out", 32'(gpio_out), 32'hC3);
    checkOutput("midtrip_released_tripped", 32'(tripped), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
